inst_encoder: RTL and testbench
===============================

// Module: inst_encoder
// PURPOSE
//  Builds 16-bit instruction words from field-level commands and writes them
//  sequentially into instruction memory. It is the inverse of the datapath
//  instruction decoder: it packs OP/RS/RT/RD/FUNCT/IMM into INST instead of
//  unpacking them. It sits between a program-load source (testbench or host
//  loader) and the instruction RAM write port. It also rejects illegal opcodes.
// PARAMETERS
//  ADDR_W     8   instruction memory address width; capacity = 2**ADDR_W words
//  BASE_ADDR  0   first write address after reset/CLR (ADDR_W bits)
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        asynchronous, active-high reset
//  CLR        in   1        synchronous restart: address, count and flags cleared
//  IN_VALID   in   1        command valid
//  IN_READY   out  1        encoder can accept a command (combinational from state)
//  IN_LAST    in   1        this command is the last of the program
//  OP         in   4        opcode
//  RS,RT,RD   in   3 each   register fields
//  FUNCT      in   3        R2R function field
//  IMM        in   6        signed immediate / branch offset
//  IMEM_WE    out  1        instruction RAM write enable
//  IMEM_ADDR  out  ADDR_W   instruction RAM write address
//  IMEM_DATA  out  16       instruction word being written
//  COUNT      out  ADDR_W+1 words written since reset/CLR
//  DONE       out  1        last word written; held until CLR
//  FULL       out  1        2**ADDR_W words written; held until CLR
//  ERR        out  1        sticky: an illegal opcode was received
// BEHAVIOUR
//  - Reset values (RST high): state IDLE, IMEM_WE=0, IMEM_ADDR=BASE_ADDR,
//    IMEM_DATA=0, COUNT=0, DONE=FULL=ERR=0.
//  - Opcodes: NOP=0000 LB=0010 SB=0100 ADDI=0101 ANDI=0110 ORI=0111 BEQ=1000
//    BNE=1001 BGEZ=1010 BLTZ=1011 R2R=1111. All other opcodes are illegal.
//  - Encoding: R2R gives {OP,RS,RT,RD,FUNCT}. LB/SB/ADDI/ANDI/ORI/branches give
//    {OP,RS,RT,IMM}. NOP gives 16'h0000, and its fields are ignored.
//  - FSM states: IDLE, WRITE, DONE, FULL. IN_READY=1 only in IDLE.
//  - IDLE, handshake (IN_VALID & IN_READY) with a legal OP: register the encoded
//    word into IMEM_DATA, latch IN_LAST, and go to WRITE.
//  - IDLE, handshake with an illegal OP: set ERR, drop the beat, ignore IN_LAST,
//    stay in IDLE, no write.
//  - WRITE: IMEM_WE=1 for exactly one cycle at the current IMEM_ADDR. On the next
//    edge, IMEM_ADDR increments modulo 2**ADDR_W and COUNT increments.
//    Next state: DONE if the latched LAST is set; else FULL if the new COUNT
//    equals 2**ADDR_W; else IDLE. DONE takes priority if both apply.
//  - Latency: write occurs the cycle after the handshake. Throughput is one word
//    per 2 cycles.
//  - DONE/FULL: IN_READY=0 and inputs are ignored until CLR.
//  - CLR has priority over any handshake in every state. A CLR in WRITE aborts
//    the write: IMEM_WE=0 that cycle. Next state is IDLE, IMEM_ADDR=BASE_ADDR,
//    COUNT=0, DONE=FULL=ERR=0. IMEM_DATA is retained.
//  - RST mid-operation: all outputs take their reset values immediately,
//    including IMEM_WE=0.
//  - With nonzero BASE_ADDR, the address wraps to 0 past 2**ADDR_W-1. FULL is
//    based on COUNT, not address.
//  - IMEM_DATA holds the last encoded word between writes.
// TESTING
//  1 Reset, then ADDI RS=1 RT=2 IMM=6'h3F -> one IMEM_WE pulse, ADDR=0, DATA=16'h52BF, COUNT=1.
//  2 R2R RS=3 RT=4 RD=5 FUNCT=2 -> DATA=16'hF72A, written the cycle after the handshake.
//  3 OP=4'b0011 -> ERR=1, no IMEM_WE, COUNT unchanged, IN_READY stays 1; next legal beat still writes.
//  4 ADDR_W=2, BASE_ADDR=1, four ORI beats -> ADDR 1,2,3,0; FULL=1, IN_READY=0; CLR -> IDLE, ADDR=1.
//  5 IN_LAST on 3rd beat -> DONE=1, COUNT=3; IN_VALID held high afterwards causes no further WE.
//  6 NOP with nonzero fields -> DATA=16'h0000; CLR in WRITE -> no WE; RST in WRITE -> WE=0 immediately.

Source files
------------

// File: rtl/inst_encoder.sv
// Packs field-level commands into 16-bit instruction words and writes them
// sequentially into instruction memory, rejecting illegal opcodes.
module inst_encoder #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              IN_LAST,
    input  logic [3:0]        OP,
    input  logic [2:0]        RS,
    input  logic [2:0]        RT,
    input  logic [2:0]        RD,
    input  logic [2:0]        FUNCT,
    input  logic [5:0]        IMM,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [15:0]       IMEM_DATA,
    output logic [ADDR_W:0]   COUNT,
    output logic              DONE,
    output logic              FULL,
    output logic              ERR
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_R2R = 4'b1111;
    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [15:0]         data_q, data_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1111: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] encode(
        input logic [3:0] op,
        input logic [2:0] rs,
        input logic [2:0] rt,
        input logic [2:0] rd,
        input logic [2:0] funct,
        input logic [5:0] imm
    );
        if (op == OP_NOP)      encode = 16'h0000;
        else if (op == OP_R2R) encode = {op, rs, rt, rd, funct};
        else                   encode = {op, rs, rt, imm};
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            data_q  <= data_d;
            last_q  <= last_d;
            done_q  <= done_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        data_d  = data_q;
        last_d  = last_q;
        done_d  = done_q;
        full_d  = full_q;
        err_d   = err_q;
        // CLR wins over everything, but the last encoded word stays visible
        if (CLR) begin
            state_d = S_IDLE;
            addr_d  = BASE_ADDR;
            count_d = '0;
            done_d  = 1'b0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (IN_VALID) begin
                        if (op_legal(OP)) begin
                            data_d  = encode(OP, RS, RT, RD, FUNCT, IMM);
                            last_d  = IN_LAST;
                            state_d = S_WRITE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_d == CAPACITY) full_d = 1'b1;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (count_d == CAPACITY) begin
                        state_d = S_FULL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        IN_READY = (state_q == S_IDLE);
        IMEM_WE  = (state_q == S_WRITE) && !CLR;
    end

    assign IMEM_ADDR = addr_q;
    assign IMEM_DATA = data_q;
    assign COUNT     = count_q;
    assign DONE      = done_q;
    assign FULL      = full_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a default instance (ADDR_W=8, BASE_ADDR=0)
// and a small one (ADDR_W=2, BASE_ADDR=1) share the same command inputs.
module tb_inst_encoder;

    logic        CLK = 1'b0;
    logic        RST, CLR, IN_VALID, IN_LAST;
    logic [3:0]  OP;
    logic [2:0]  RS, RT, RD, FUNCT;
    logic [5:0]  IMM;

    logic        a_ready, a_we, a_done, a_full, a_err;
    logic [7:0]  a_addr;
    logic [15:0] a_data;
    logic [8:0]  a_count;

    logic        b_ready, b_we, b_done, b_full, b_err;
    logic [1:0]  b_addr;
    logic [15:0] b_data;
    logic [2:0]  b_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    inst_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut_a (
        .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(a_ready),
        .IN_LAST(IN_LAST), .OP(OP), .RS(RS), .RT(RT), .RD(RD), .FUNCT(FUNCT), .IMM(IMM),
        .IMEM_WE(a_we), .IMEM_ADDR(a_addr), .IMEM_DATA(a_data), .COUNT(a_count),
        .DONE(a_done), .FULL(a_full), .ERR(a_err)
    );

    inst_encoder #(.ADDR_W(2), .BASE_ADDR(2'd1)) dut_b (
        .CLK(CLK), .RST(RST), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(b_ready),
        .IN_LAST(IN_LAST), .OP(OP), .RS(RS), .RT(RT), .RD(RD), .FUNCT(FUNCT), .IMM(IMM),
        .IMEM_WE(b_we), .IMEM_ADDR(b_addr), .IMEM_DATA(b_data), .COUNT(b_count),
        .DONE(b_done), .FULL(b_full), .ERR(b_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle command beat; returns #1 after the accepting edge.
    task automatic beat(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic [2:0] funct, input logic [5:0] imm,
                        input logic last);
        OP = op; RS = rs; RT = rt; RD = rd; FUNCT = funct; IMM = imm;
        IN_LAST = last; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    task automatic clear();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
    endtask

    logic [1:0]  b_addr_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] b_data_exp [4] = '{16'h71CA, 16'h73CB, 16'h75CC, 16'h77CD};
    int we_sum;

    initial begin
        RST = 1'b1; CLR = 1'b0; IN_VALID = 1'b0; IN_LAST = 1'b0;
        OP = '0; RS = '0; RT = '0; RD = '0; FUNCT = '0; IMM = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        check_eq("rst_we",    a_we,    0);
        check_eq("rst_addr",  a_addr,  0);
        check_eq("rst_data",  a_data,  0);
        check_eq("rst_count", a_count, 0);
        check_eq("rst_flags", {a_done, a_full, a_err}, 0);
        check_eq("rst_ready", a_ready, 1);
        check_eq("rst_baddr", b_addr,  1);

        // ADDI
        beat(4'b0101, 3'd1, 3'd2, 3'd0, 3'd0, 6'h3F, 1'b0);
        check_eq("addi_we",    a_we,    1);
        check_eq("addi_addr",  a_addr,  0);
        check_eq("addi_data",  a_data,  16'h52BF);
        check_eq("addi_ready", a_ready, 0);
        step();
        check_eq("addi_we_off", a_we,    0);
        check_eq("addi_count",  a_count, 1);
        check_eq("addi_addr1",  a_addr,  1);

        // R2R
        beat(4'b1111, 3'd3, 3'd4, 3'd5, 3'd2, 6'h00, 1'b0);
        check_eq("r2r_we",   a_we,   1);
        check_eq("r2r_data", a_data, 16'hF72A);
        check_eq("r2r_addr", a_addr, 1);
        step();
        check_eq("r2r_count", a_count, 2);

        // illegal opcode
        beat(4'b0011, 3'd1, 3'd1, 3'd1, 3'd1, 6'h01, 1'b1);
        check_eq("ill_err",   a_err,   1);
        check_eq("ill_we",    a_we,    0);
        check_eq("ill_ready", a_ready, 1);
        check_eq("ill_count", a_count, 2);
        check_eq("ill_data",  a_data,  16'hF72A);
        beat(4'b0110, 3'd2, 3'd3, 3'd0, 3'd0, 6'h05, 1'b0);
        check_eq("andi_we",   a_we,   1);
        check_eq("andi_addr", a_addr, 2);
        check_eq("andi_data", a_data, 16'h64C5);
        step();
        check_eq("andi_count", a_count, 3);
        check_eq("andi_err",   a_err,   1);

        // small instance: wrap and FULL
        clear();
        check_eq("clr_err",    a_err,   0);
        check_eq("clr_count",  a_count, 0);
        check_eq("clr_baddr",  b_addr,  1);
        check_eq("clr_bcount", b_count, 0);
        for (int i = 0; i < 4; i++) begin
            beat(4'b0111, 3'(i), 3'd7, 3'd0, 3'd0, 6'(10 + i), 1'b0);
            check_eq("ori_we",   b_we,   1);
            check_eq("ori_addr", b_addr, b_addr_exp[i]);
            check_eq("ori_data", b_data, b_data_exp[i]);
            step();
        end
        check_eq("full_flag",  b_full,  1);
        check_eq("full_ready", b_ready, 0);
        check_eq("full_count", b_count, 4);
        check_eq("full_addr",  b_addr,  1);
        check_eq("full_done",  b_done,  0);
        beat(4'b0111, 3'd1, 3'd1, 3'd0, 3'd0, 6'h01, 1'b0);
        check_eq("full_no_we", b_we, 0);
        clear();
        check_eq("full_clr_addr",  b_addr,  1);
        check_eq("full_clr_flag",  b_full,  0);
        check_eq("full_clr_ready", b_ready, 1);

        // IN_LAST on the third beat
        for (int i = 0; i < 3; i++) begin
            beat(4'b1000, 3'd1, 3'd2, 3'd0, 3'd0, 6'h3E, (i == 2));
            step();
        end
        check_eq("last_done",  a_done,  1);
        check_eq("last_count", a_count, 3);
        check_eq("last_ready", a_ready, 0);
        check_eq("last_full",  a_full,  0);
        OP = 4'b0101; IN_VALID = 1'b1;
        we_sum = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            we_sum += int'(a_we);
        end
        IN_VALID = 1'b0;
        check_eq("last_no_we",  we_sum,  0);
        check_eq("last_count2", a_count, 3);

        // NOP, CLR in WRITE, RST in WRITE
        clear();
        beat(4'b0000, 3'd7, 3'd7, 3'd7, 3'd7, 6'h3F, 1'b0);
        check_eq("nop_we",   a_we,   1);
        check_eq("nop_data", a_data, 16'h0000);
        step();
        check_eq("nop_count", a_count, 1);
        beat(4'b0101, 3'd7, 3'd0, 3'd0, 3'd0, 6'h01, 1'b0);
        CLR = 1'b1;
        #1;
        check_eq("clrw_we", a_we, 0);
        step();
        CLR = 1'b0;
        check_eq("clrw_count", a_count, 0);
        check_eq("clrw_addr",  a_addr,  0);
        check_eq("clrw_data",  a_data,  16'h5E01);
        check_eq("clrw_ready", a_ready, 1);
        beat(4'b0110, 3'd2, 3'd3, 3'd0, 3'd0, 6'h05, 1'b0);
        check_eq("rstw_pre_we", a_we, 1);
        RST = 1'b1;
        #1;
        check_eq("rstw_we",   a_we,   0);
        check_eq("rstw_data", a_data, 0);
        check_eq("rstw_addr", a_addr, 0);
        check_eq("rstw_baddr", b_addr, 1);
        step();
        RST = 1'b0;
        check_eq("rstw_ready", a_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
